// File: rtl/alu_issue_queue.sv
// Issue stage in front of the ALU: queues decoded ops, issues one at a time with
// operands and mode held stable, and returns result + tag on a valid/ready port.
module alu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_op_a,
    input  logic [31:0]            in_op_b,
    input  logic [3:0]             in_alu_op,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   mode_fast_req,
    output logic                   start_exec,
    output logic                   mode_fast,
    output logic [31:0]            op_a,
    output logic [31:0]            op_b,
    output logic [3:0]             alu_op,
    input  logic [31:0]            alu_result,
    input  logic                   alu_busy,
    input  logic                   alu_done,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [31:0]            wb_result,
    output logic [TAG_W-1:0]       wb_tag,
    output logic                   wb_timeout,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_WB
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      fifo_a   [DEPTH];
    logic [31:0]      fifo_b   [DEPTH];
    logic [3:0]       fifo_op  [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WD_W-1:0]  wdog;
    logic [TAG_W-1:0] tag_q;
    logic             push;
    logic             pop;
    logic             wd_expired;

    assign in_ready   = (q_count != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && (q_count != '0) && !alu_busy;
    assign wd_expired = (wdog == WD_LAST);

    // Queue storage carries data only; occupancy lives in the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= in_op_a;
            fifo_b[wr_ptr]   <= in_op_b;
            fifo_op[wr_ptr]  <= in_alu_op;
            fifo_tag[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + (PTR_W + 1)'(1);
                2'b01:   q_count <= q_count - (PTR_W + 1)'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_exec = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_exec = 1'b1;
                state_nxt  = alu_done ? S_CAPT : S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    state_nxt = S_CAPT;
                end else if (wd_expired) begin
                    state_nxt = S_WB;
                end
            end
            S_CAPT: begin
                state_nxt = S_WB;
            end
            S_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Exec regs load only on pop, so they stay frozen from ISSUE through WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            alu_op     <= '0;
            tag_q      <= '0;
            mode_fast  <= 1'b0;
            wdog       <= '0;
            wb_result  <= '0;
            wb_tag     <= '0;
            wb_timeout <= 1'b0;
        end else begin
            if (pop) begin
                op_a      <= fifo_a[rd_ptr];
                op_b      <= fifo_b[rd_ptr];
                alu_op    <= fifo_op[rd_ptr];
                tag_q     <= fifo_tag[rd_ptr];
                mode_fast <= mode_fast_req;
            end
            case (state)
                S_ISSUE: begin
                    wdog <= '0;
                end
                S_WAIT: begin
                    wdog <= wdog + WD_W'(1);
                    if (!alu_done && wd_expired) begin
                        wb_result  <= '0;
                        wb_tag     <= tag_q;
                        wb_timeout <= 1'b1;
                    end
                end
                S_CAPT: begin
                    wb_result  <= alu_result;
                    wb_tag     <= tag_q;
                    wb_timeout <= 1'b0;
                end
                default: begin
                    wdog <= wdog;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: stub ALU with fast/low-power latency, scoreboard of
// expected writebacks, one task per scenario.
module tb_alu_issue_queue;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_op_a;
    logic [31:0]            in_op_b;
    logic [3:0]             in_alu_op;
    logic [TAG_W-1:0]       in_tag;
    logic                   mode_fast_req;
    logic                   start_exec;
    logic                   mode_fast;
    logic [31:0]            op_a;
    logic [31:0]            op_b;
    logic [3:0]             alu_op;
    logic [31:0]            alu_result;
    logic                   alu_busy;
    logic                   alu_done;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [31:0]            wb_result;
    logic [TAG_W-1:0]       wb_tag;
    logic                   wb_timeout;
    logic [$clog2(DEPTH):0] q_count;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             to;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic        stub_en;
    logic        busy_force;
    logic [1:0]  lp_cnt;
    logic [31:0] res_q;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_alu_op(in_alu_op), .in_tag(in_tag),
        .mode_fast_req(mode_fast_req),
        .start_exec(start_exec), .mode_fast(mode_fast),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_busy(alu_busy), .alu_done(alu_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_result(wb_result), .wb_tag(wb_tag), .wb_timeout(wb_timeout),
        .q_count(q_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    // Stub ALU: fast mode finishes in the issue cycle, low-power two cycles later;
    // result appears the cycle after done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_cnt <= 2'd0;
            res_q  <= 32'd0;
        end else begin
            if (start_exec && !mode_fast) lp_cnt <= 2'd2;
            else if (lp_cnt != 2'd0)      lp_cnt <= lp_cnt - 2'd1;
            if (alu_done) res_q <= exp_alu(op_a, op_b, alu_op);
        end
    end
    assign alu_done   = stub_en & ((start_exec & mode_fast) | (lp_cnt == 2'd1));
    assign alu_busy   = busy_force | (lp_cnt != 2'd0);
    assign alu_result = res_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic to);
        exp_t e;
        in_valid  = 1'b1;
        in_op_a   = a;
        in_op_b   = b;
        in_alu_op = op;
        in_tag    = tag;
        step();
        in_valid  = 1'b0;
        e.res = res;
        e.tag = tag;
        e.to  = to;
        sb.push_back(e);
    endtask

    task automatic wait_start(input int bound, output bit seen, output int t);
        seen = 1'b0;
        t    = cyc;
        for (int i = 0; i < bound; i++) begin
            if (start_exec) begin
                seen = 1'b1;
                t    = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic wait_wb(input int bound, output bit seen, output int t);
        seen = 1'b0;
        t    = cyc;
        for (int i = 0; i < bound; i++) begin
            if (wb_valid) begin
                seen = 1'b1;
                t    = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit leak;
        stub_en = 1'b0; mode_fast_req = 1'b1; wb_ready = 1'b1;
        push_op(32'hAAAA_0001, 32'h2, 4'd0, 4'd9, 32'd0, 1'b0);
        push_op(32'h1, 32'h2, 4'd0, 4'd10, 32'd0, 1'b0);
        push_op(32'h3, 32'h4, 4'd1, 4'd11, 32'd0, 1'b0);
        push_op(32'h5, 32'h6, 4'd2, 4'd12, 32'd0, 1'b0);
        repeat (2) step();
        n_vec++; if (q_count !== 3'd3) begin n_err++; $display("FAIL rst_pre_count: got %0d want 3", q_count); end
        n_vec++; if (op_a !== 32'hAAAA_0001) begin n_err++; $display("FAIL rst_pre_op_a: got %h want aaaa0001", op_a); end
        n_vec++; if (mode_fast !== 1'b1) begin n_err++; $display("FAIL rst_pre_mode: got %b want 1", mode_fast); end
        rst = 1'b1;
        #1;
        n_vec++; if (q_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", q_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if ({start_exec, wb_valid, wb_timeout, mode_fast} !== 4'b0) begin
            n_err++; $display("FAIL rst_ctrl: got se/wv/to/mf=%b want 0000", {start_exec, wb_valid, wb_timeout, mode_fast}); end
        n_vec++; if ({op_a, op_b, alu_op} !== 68'd0) begin
            n_err++; $display("FAIL rst_exec_regs: got a=%h b=%h op=%h want 0", op_a, op_b, alu_op); end
        n_vec++; if ({wb_result, wb_tag} !== '0) begin
            n_err++; $display("FAIL rst_wb_regs: got res=%h tag=%h want 0", wb_result, wb_tag); end
        step();
        rst = 1'b0;
        sb.delete();
        leak = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (wb_valid || start_exec) leak = 1'b1;
            step();
        end
        n_vec++; if (leak !== 1'b0) begin n_err++; $display("FAIL rst_no_leak: got activity=%b want 0", leak); end
        stub_en = 1'b1;
    endtask

    task automatic test_fast();
        bit seen; int t_iss, t_wb; exp_t e;
        stub_en = 1'b1; mode_fast_req = 1'b1; wb_ready = 1'b1;
        push_op(32'd5, 32'd3, 4'd0, 4'd1, 32'd8, 1'b0);
        wait_start(20, seen, t_iss);
        n_vec++; if (!seen) begin n_err++; $display("FAIL fast_issue: start_exec seen=%b want 1", seen); end
        n_vec++; if (mode_fast !== 1'b1) begin n_err++; $display("FAIL fast_mode: got %b want 1", mode_fast); end
        wait_wb(20, seen, t_wb);
        n_vec++; if (!seen || (t_wb - t_iss) != 2) begin
            n_err++; $display("FAIL fast_latency: got %0d (seen=%b) want 2", t_wb - t_iss, seen); end
        e = sb.pop_front();
        n_vec++; if (wb_result !== e.res) begin n_err++; $display("FAIL fast_result: got %h want %h", wb_result, e.res); end
        n_vec++; if (wb_tag !== e.tag) begin n_err++; $display("FAIL fast_tag: got %h want %h", wb_tag, e.tag); end
        n_vec++; if (wb_timeout !== e.to) begin n_err++; $display("FAIL fast_timeout: got %b want %b", wb_timeout, e.to); end
        step();
    endtask

    task automatic test_low_power();
        bit seen, stable; int t_iss, t_wb; exp_t e;
        stub_en = 1'b1; mode_fast_req = 1'b0; wb_ready = 1'b1;
        push_op(32'h10, 32'h4, 4'd1, 4'd2, 32'h0C, 1'b0);
        wait_start(20, seen, t_iss);
        n_vec++; if (mode_fast !== 1'b0) begin n_err++; $display("FAIL lp_mode: got %b want 0", mode_fast); end
        stable = 1'b1;
        t_wb = cyc;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (op_a !== 32'h10 || op_b !== 32'h4 || alu_op !== 4'd1) stable = 1'b0;
            if (wb_valid) begin seen = 1'b1; t_wb = cyc; break; end
            step();
        end
        n_vec++; if (!seen || (t_wb - t_iss) != 4) begin
            n_err++; $display("FAIL lp_latency: got %0d (seen=%b) want 4", t_wb - t_iss, seen); end
        n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL lp_operands_held: got stable=%b want 1", stable); end
        e = sb.pop_front();
        n_vec++; if (wb_result !== e.res) begin n_err++; $display("FAIL lp_result: got %h want %h", wb_result, e.res); end
        n_vec++; if (wb_tag !== e.tag) begin n_err++; $display("FAIL lp_tag: got %h want %h", wb_tag, e.tag); end
        step();
    endtask

    task automatic test_full_backpressure();
        bit seen, held; int t; exp_t e;
        stub_en = 1'b1; mode_fast_req = 1'b1; wb_ready = 1'b0; busy_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_op(32'(100 + i * 7), 32'(i * 3 + 1), 4'(i), TAG_W'(i),
                    exp_alu(32'(100 + i * 7), 32'(i * 3 + 1), 4'(i)), 1'b0);
        end
        n_vec++; if (q_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", q_count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b1; in_op_a = 32'hDEAD; in_op_b = 32'hBEEF; in_alu_op = 4'd0; in_tag = 4'hF;
        step();
        in_valid = 1'b0;
        n_vec++; if (q_count !== 3'd4) begin n_err++; $display("FAIL full_no_push: got %0d want 4", q_count); end
        busy_force = 1'b0;
        wait_wb(20, seen, t);
        held = seen;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!wb_valid || wb_tag !== 4'd0 || start_exec) held = 1'b0;
        end
        n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL stall_hold: got held=%b want 1", held); end
        wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_wb(20, seen, t);
            e = sb.pop_front();
            n_vec++; if (!seen || wb_tag !== e.tag || wb_result !== e.res || wb_timeout !== e.to) begin
                n_err++; $display("FAIL order_%0d: got tag=%h res=%h to=%b want tag=%h res=%h to=%b",
                                  k, wb_tag, wb_result, wb_timeout, e.tag, e.res, e.to); end
            step();
        end
    endtask

    task automatic test_mode_change();
        bit seen, kept; int t_iss, t_wb; exp_t e;
        stub_en = 1'b1; wb_ready = 1'b1; mode_fast_req = 1'b0;
        push_op(32'h2F, 32'h1C, 4'd2, 4'd5, 32'h0C, 1'b0);
        push_op(32'h40, 32'h02, 4'd3, 4'd6, 32'h42, 1'b0);
        wait_start(20, seen, t_iss);
        n_vec++; if (!seen || mode_fast !== 1'b0) begin
            n_err++; $display("FAIL mc_first_mode: got %b (seen=%b) want 0", mode_fast, seen); end
        step();
        mode_fast_req = 1'b1;
        kept = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mode_fast !== 1'b0) kept = 1'b0;
            if (wb_valid) begin seen = 1'b1; break; end
            step();
        end
        n_vec++; if (!seen || kept !== 1'b1) begin
            n_err++; $display("FAIL mc_mode_held: got kept=%b seen=%b want 1 1", kept, seen); end
        e = sb.pop_front();
        n_vec++; if (wb_result !== e.res || wb_tag !== e.tag) begin
            n_err++; $display("FAIL mc_first_wb: got res=%h tag=%h want res=%h tag=%h", wb_result, wb_tag, e.res, e.tag); end
        step();
        wait_start(20, seen, t_iss);
        n_vec++; if (!seen || mode_fast !== 1'b1) begin
            n_err++; $display("FAIL mc_next_mode: got %b (seen=%b) want 1", mode_fast, seen); end
        wait_wb(20, seen, t_wb);
        e = sb.pop_front();
        n_vec++; if (!seen || (t_wb - t_iss) != 2 || wb_result !== e.res || wb_tag !== e.tag) begin
            n_err++; $display("FAIL mc_next_wb: got lat=%0d res=%h tag=%h want lat=2 res=%h tag=%h",
                              t_wb - t_iss, wb_result, wb_tag, e.res, e.tag); end
        step();
    endtask

    task automatic test_timeout();
        bit seen; int t_iss, t_wb; exp_t e;
        stub_en = 1'b0; mode_fast_req = 1'b1; wb_ready = 1'b1;
        push_op(32'h11, 32'h22, 4'd0, 4'd7, 32'd0, 1'b1);
        wait_start(20, seen, t_iss);
        wait_wb(60, seen, t_wb);
        n_vec++; if (!seen || (t_wb - t_iss) != TIMEOUT + 1) begin
            n_err++; $display("FAIL to_latency: got %0d (seen=%b) want %0d", t_wb - t_iss, seen, TIMEOUT + 1); end
        e = sb.pop_front();
        n_vec++; if (wb_timeout !== e.to) begin n_err++; $display("FAIL to_flag: got %b want %b", wb_timeout, e.to); end
        n_vec++; if (wb_result !== e.res) begin n_err++; $display("FAIL to_result: got %h want %h", wb_result, e.res); end
        n_vec++; if (wb_tag !== e.tag) begin n_err++; $display("FAIL to_tag: got %h want %h", wb_tag, e.tag); end
        step();
        stub_en = 1'b1;
        push_op(32'd9, 32'd4, 4'd0, 4'd8, 32'd13, 1'b0);
        wait_start(20, seen, t_iss);
        wait_wb(20, seen, t_wb);
        e = sb.pop_front();
        n_vec++; if (!seen || (t_wb - t_iss) != 2 || wb_result !== e.res || wb_tag !== e.tag || wb_timeout !== e.to) begin
            n_err++; $display("FAIL to_recover: got lat=%0d res=%h tag=%h to=%b want lat=2 res=%h tag=%h to=%b",
                              t_wb - t_iss, wb_result, wb_tag, wb_timeout, e.res, e.tag, e.to); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op_a = '0; in_op_b = '0; in_alu_op = '0; in_tag = '0;
        mode_fast_req = 1'b0; wb_ready = 1'b1; stub_en = 1'b1; busy_force = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        test_reset();
        test_fast();
        test_low_power();
        test_full_backpressure();
        test_mode_change();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
